// File: rtl/burst_pkg.sv
// Shared types and sizing helpers for the cache-line <-> memory-burst adapter.
package burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RESP    = 3'd4
  } burst_state_t;

  function automatic int beats_per_line(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/line_burst_adapter.sv
// Splits a cache line into memory write beats and assembles address-matched read
// beats into a line, with a single-cycle completion pulse back to the cache.
module line_burst_adapter
  import burst_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BUS_W-1:0]  bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BUS_W-1:0]  bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int                BEATS    = beats_per_line(LINE_W, BUS_W);
  localparam int                CNT_W    = cnt_width(BEATS);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_W / 8 - 1);

  burst_state_t      r_state;
  burst_state_t      w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_acc;
  logic [LINE_W-1:0] r_rdata;
  logic              w_hit;
  logic              w_last;
  logic [LINE_W-1:0] w_line;
  logic [BUS_W-1:0]  w_wbeat;

  // Only beats tagged with our own line address count; stale returns are dropped.
  assign w_hit   = (r_state == ST_RD_DATA) && bmem_rvalid && (bmem_raddr == r_addr);
  assign w_last  = (r_cnt == LAST);
  assign w_wbeat = r_wdata[r_cnt*BUS_W +: BUS_W];

  always_comb begin
    w_line = r_acc;
    w_line[r_cnt*BUS_W +: BUS_W] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dfp_write)     w_next = ST_WR_DATA;
        else if (dfp_read) w_next = ST_RD_REQ;
      end
      ST_RD_REQ:  if (bmem_ready)           w_next = ST_RD_DATA;
      ST_RD_DATA: if (w_hit && w_last)      w_next = ST_RESP;
      ST_WR_DATA: if (bmem_ready && w_last) w_next = ST_RESP;
      ST_RESP:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    case (r_state)
      ST_RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = r_addr;
      end
      ST_WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = r_addr;
        bmem_wdata = w_wbeat;
      end
      ST_RESP:  dfp_resp = 1'b1;
      default: ;
    endcase
  end

  // Request latch, beat counter and read-line accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dfp_write || dfp_read) begin
            r_addr <= dfp_addr & ~OFS_MASK;
            r_cnt  <= '0;
          end
          if (dfp_write) r_wdata <= dfp_wdata;
        end
        ST_RD_REQ: begin
          if (bmem_ready) r_cnt <= '0;
        end
        ST_RD_DATA: begin
          if (w_hit) begin
            r_acc <= w_line;
            if (w_last) begin
              r_rdata <= w_line;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_WR_DATA: begin
          if (bmem_ready) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dfp_rdata = r_rdata;

endmodule
